// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the IF stage: fetch FSM states, word size,
// PC increment and the default reset vector.
package instr_fetch_pkg;

  localparam int          INSTR_W              = 32;
  localparam int          PC_INC               = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    GIVE  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// IF stage: holds the PC, fetches one word at a time over req/gnt/rvalid,
// hands it to ID with give/get and squashes wrong-path fetches on redirect.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                 BITSIZE      = 32,
  parameter logic [BITSIZE-1:0] RESET_VECTOR = BITSIZE'(DEFAULT_RESET_VECTOR)
) (
  input  logic                clk,
  input  logic                resetn_i,
  output logic                IF_ID_give_o,
  input  logic                ID_IF_get_i,
  output logic [INSTR_W-1:0]  IF_ID_instr_o,
  output logic [BITSIZE-1:0]  IF_ID_pc_o,
  output logic                IF_MEM_req_o,
  output logic [BITSIZE-1:0]  IF_MEM_addr_o,
  input  logic                MEM_IF_gnt_i,
  input  logic                MEM_IF_rvalid_i,
  input  logic [INSTR_W-1:0]  MEM_IF_rdata_i,
  input  logic                EX_IF_redirect_i,
  input  logic [BITSIZE-1:0]  EX_IF_target_i
);

  fetch_state_t       state_r;
  fetch_state_t       next_state_s;
  logic [BITSIZE-1:0] pc_r;
  logic [BITSIZE-1:0] next_pc_s;
  logic [BITSIZE-1:0] pc_step_s;
  logic [BITSIZE-1:0] target_aligned_s;
  logic               discard_r;
  logic               next_discard_s;
  logic               active_r;
  logic [INSTR_W-1:0] instr_r;
  logic [BITSIZE-1:0] out_pc_r;
  logic               load_out_s;
  logic               give_s;
  logic               req_s;

  assign target_aligned_s = EX_IF_target_i & ~(BITSIZE'(3));

  // Next state, next PC, discard tracking and handshake outputs
  always_comb begin
    next_state_s   = state_r;
    pc_step_s      = pc_r;
    next_pc_s      = pc_r;
    next_discard_s = discard_r;
    load_out_s     = 1'b0;
    give_s         = 1'b0;
    req_s          = 1'b0;
    case (state_r)
      FETCH: begin
        // active_r keeps req low until the first clock after reset release
        req_s = active_r;
        if (active_r && MEM_IF_gnt_i) begin
          next_state_s   = WAIT;
          next_discard_s = EX_IF_redirect_i;
        end else begin
          next_state_s   = FETCH;
        end
      end
      WAIT: begin
        if (MEM_IF_rvalid_i) begin
          next_discard_s = 1'b0;
          if (discard_r || EX_IF_redirect_i) begin
            next_state_s = FETCH;
          end else begin
            next_state_s = GIVE;
            load_out_s   = 1'b1;
          end
        end else if (EX_IF_redirect_i) begin
          next_discard_s = 1'b1;
        end else begin
          next_discard_s = discard_r;
        end
      end
      GIVE: begin
        give_s = ~EX_IF_redirect_i;
        if (EX_IF_redirect_i) begin
          next_state_s = FETCH;
        end else if (ID_IF_get_i) begin
          next_state_s = FETCH;
          pc_step_s    = pc_r + BITSIZE'(PC_INC);
        end else begin
          next_state_s = GIVE;
        end
      end
      default: begin
        next_state_s = FETCH;
      end
    endcase
    // A redirect overrides any sequential PC step, including a same-cycle transfer
    if (EX_IF_redirect_i) begin
      next_pc_s = target_aligned_s;
    end else begin
      next_pc_s = pc_step_s;
    end
  end

  // State, PC, discard flag and output holding registers
  always_ff @(posedge clk or negedge resetn_i) begin
    if (!resetn_i) begin
      state_r   <= FETCH;
      pc_r      <= RESET_VECTOR;
      discard_r <= 1'b0;
      active_r  <= 1'b0;
      instr_r   <= '0;
      out_pc_r  <= '0;
    end else begin
      state_r   <= next_state_s;
      pc_r      <= next_pc_s;
      discard_r <= next_discard_s;
      active_r  <= 1'b1;
      if (load_out_s) begin
        instr_r  <= MEM_IF_rdata_i;
        out_pc_r <= pc_r;
      end
    end
  end

  assign IF_ID_give_o  = give_s;
  assign IF_ID_instr_o = instr_r;
  assign IF_ID_pc_o    = out_pc_r;
  assign IF_MEM_req_o  = req_s;
  assign IF_MEM_addr_o = pc_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized memory/ID/EX
// environment checked every cycle against an architectural PC model.
module tb_instr_fetch;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        get;
  logic        gnt;
  logic        rvalid;
  logic        redirect;
  logic [31:0] rdata;
  logic [31:0] target;
  logic        give;
  logic        req;
  logic [31:0] instr;
  logic [31:0] pc_o;
  logic [31:0] addr;

  int          checks = 0;
  int          errors = 0;

  // architectural model state
  logic [31:0] arch_pc;
  int          outstanding;
  bit          stall_hold;
  logic [31:0] held_pc;
  logic [31:0] held_instr;
  int          transfers = 0;

  // bench memory state
  bit          mem_pend;
  logic [31:0] mem_addr;
  int          mem_dly;

  instr_fetch #(.BITSIZE(32), .RESET_VECTOR(RV)) dut (
    .clk              (clk),
    .resetn_i         (resetn),
    .IF_ID_give_o     (give),
    .ID_IF_get_i      (get),
    .IF_ID_instr_o    (instr),
    .IF_ID_pc_o       (pc_o),
    .IF_MEM_req_o     (req),
    .IF_MEM_addr_o    (addr),
    .MEM_IF_gnt_i     (gnt),
    .MEM_IF_rvalid_i  (rvalid),
    .MEM_IF_rdata_i   (rdata),
    .EX_IF_redirect_i (redirect),
    .EX_IF_target_i   (target)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural view: delivered words follow PC+4 from the last redirect target
  task automatic model_check();
    if (!resetn) begin
      chk("rst_give", {31'd0, give}, 32'd0);
      chk("rst_req", {31'd0, req}, 32'd0);
      arch_pc     = RV;
      outstanding = 0;
      stall_hold  = 1'b0;
      return;
    end
    if (outstanding != 0) chk("one_outstanding_req", {31'd0, req}, 32'd0);
    if (redirect) chk("redirect_kills_give", {31'd0, give}, 32'd0);
    if (stall_hold) begin
      chk("stall_pc_stable", pc_o, held_pc);
      chk("stall_instr_stable", instr, held_instr);
      if (!redirect) chk("stall_give_held", {31'd0, give}, 32'd1);
    end
    if (req && gnt && !redirect) chk("req_addr", addr, arch_pc);
    if (give && get) begin
      chk("xfer_pc", pc_o, arch_pc);
      chk("xfer_instr", instr, mem_word(arch_pc));
      arch_pc = arch_pc + 32'd4;
      transfers++;
    end
    if (req && gnt) outstanding++;
    if (rvalid) outstanding--;
    stall_hold = give && !get && !redirect;
    held_pc    = pc_o;
    held_instr = instr;
    if (redirect) arch_pc = target & 32'hFFFF_FFFC;
  endtask

  task automatic sample();
    #4;
    model_check();
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  task automatic set_in(input logic gt, input logic rv, input logic [31:0] rd,
                        input logic gg, input logic rdr, input logic [31:0] tg);
    gnt = gt; rvalid = rv; rdata = rd; get = gg; redirect = rdr; target = tg;
  endtask

  initial begin
    int rand_start;
    resetn = 1'b0;
    set_in(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    mem_pend = 1'b0; mem_addr = 32'd0; mem_dly = 0;
    arch_pc = RV; outstanding = 0; stall_hold = 1'b0; held_pc = 32'd0; held_instr = 32'd0;
    @(negedge clk);
    repeat (2) begin sample(); next(); end

    // 1: first fetch after reset release, minimum latency
    resetn = 1'b1;
    sample(); chk("t1_req_before_clk", {31'd0, req}, 32'd0); next();
    set_in(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    sample(); chk("t1_req", {31'd0, req}, 32'd1); chk("t1_addr", addr, 32'h0); next();
    set_in(1'b0, 1'b1, 32'h0050_0093, 1'b1, 1'b0, 32'd0);
    sample(); chk("t1_wait_req", {31'd0, req}, 32'd0); chk("t1_wait_give", {31'd0, give}, 32'd0); next();
    set_in(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    sample(); chk("t1_give", {31'd0, give}, 32'd1); chk("t1_instr", instr, 32'h0050_0093);
    chk("t1_pc", pc_o, 32'h0); next();
    set_in(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    sample(); chk("t1_next_req", {31'd0, req}, 32'd1); chk("t1_next_addr", addr, 32'h4); next();

    // 2: ID stalls for 5 cycles
    set_in(1'b0, 1'b1, mem_word(32'h4), 1'b0, 1'b0, 32'd0);
    sample(); next();
    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      sample();
      chk("t2_give", {31'd0, give}, 32'd1); chk("t2_pc", pc_o, 32'h4);
      chk("t2_instr", instr, mem_word(32'h4)); chk("t2_req", {31'd0, req}, 32'd0);
      chk("t2_fetch_pc_held", addr, 32'h4);
      next();
    end
    set_in(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    sample(); chk("t2_give_on_get", {31'd0, give}, 32'd1); next();
    set_in(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    sample(); chk("t2_next_addr", addr, 32'h8); next();

    // 3: redirect while waiting; late data must be dropped
    set_in(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0100);
    sample(); chk("t3_give_redir", {31'd0, give}, 32'd0); next();
    set_in(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'd0);
    sample(); chk("t3_give_drop", {31'd0, give}, 32'd0); chk("t3_req_drop", {31'd0, req}, 32'd0); next();
    set_in(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    sample(); chk("t3_give_after", {31'd0, give}, 32'd0); chk("t3_addr", addr, 32'h0000_0100); next();
    set_in(1'b0, 1'b1, mem_word(32'h100), 1'b1, 1'b0, 32'd0);
    sample(); next();

    // 4: redirect in GIVE with get=1 wins over the transfer
    set_in(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0203);
    sample(); chk("t4_give_forced_low", {31'd0, give}, 32'd0); next();

    // 5: gnt withheld three cycles, redirect in the second
    set_in(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    sample(); chk("t4_next_addr", addr, 32'h0000_0200); chk("t5_req1", {31'd0, req}, 32'd1); next();
    set_in(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0300);
    sample(); chk("t5_addr_held", addr, 32'h0000_0200); chk("t5_req2", {31'd0, req}, 32'd1); next();
    set_in(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    sample(); chk("t5_addr_target", addr, 32'h0000_0300); chk("t5_req3", {31'd0, req}, 32'd1); next();
    set_in(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    sample(); chk("t5_gnt_addr", addr, 32'h0000_0300); next();
    set_in(1'b0, 1'b1, mem_word(32'h300), 1'b1, 1'b0, 32'd0);
    sample(); next();
    set_in(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    sample(); chk("t5_give", {31'd0, give}, 32'd1); chk("t5_pc", pc_o, 32'h0000_0300); next();

    // 6: async reset while in GIVE, then PC wrap-around
    set_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    sample(); chk("t6_addr", addr, 32'h0000_0304); next();
    set_in(1'b0, 1'b1, mem_word(32'h304), 1'b0, 1'b0, 32'd0);
    sample(); next();
    set_in(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    #2;
    chk("t6_give_pre_reset", {31'd0, give}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("t6_rst_give", {31'd0, give}, 32'd0); chk("t6_rst_req", {31'd0, req}, 32'd0);
    chk("t6_rst_instr", instr, 32'd0); chk("t6_rst_pc_o", pc_o, 32'd0); chk("t6_rst_addr", addr, RV);
    next();
    repeat (2) begin sample(); next(); end
    resetn = 1'b1;
    sample(); chk("t6_req_before_clk", {31'd0, req}, 32'd0); next();
    set_in(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    sample(); chk("t6_req_after_release", {31'd0, req}, 32'd1); chk("t6_addr0", addr, 32'h0); next();
    set_in(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    sample(); chk("t6_addr_top", addr, 32'hFFFF_FFFC); next();
    set_in(1'b0, 1'b1, mem_word(32'hFFFF_FFFC), 1'b1, 1'b0, 32'd0);
    sample(); next();
    set_in(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    sample(); chk("t6_give_top", {31'd0, give}, 32'd1); chk("t6_pc_top", pc_o, 32'hFFFF_FFFC); next();
    set_in(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    sample(); chk("t6_wrap_addr", addr, 32'h0); chk("t6_wrap_req", {31'd0, req}, 32'd1); next();

    // randomized environment
    rand_start = transfers;
    mem_pend = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rvalid = 1'b0;
      rdata  = $urandom;
      if (mem_pend) begin
        if (mem_dly == 0) begin
          rvalid   = 1'b1;
          rdata    = mem_word(mem_addr);
          mem_pend = 1'b0;
        end else begin
          mem_dly--;
        end
      end
      gnt = req && ($urandom_range(0, 2) != 0);
      if (gnt) begin
        mem_pend = 1'b1;
        mem_addr = addr;
        mem_dly  = $urandom_range(0, 3);
      end
      get      = ($urandom_range(0, 9) < 7);
      redirect = !redirect && ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) target = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
      else target = $urandom & 32'h0000_0FFF;
      sample();
      next();
    end
    chk("random_transfers_seen", ((transfers - rand_start) > 100) ? 32'd1 : 32'd0, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
